// File: rtl/udp_oe_tx_hdr_gen.sv
// UDP offload engine TX header generator: latches addressing and length, sums the
// IPv4 header checksum one word per cycle, then streams the 42-byte header as 64-bit beats.
//
// State | meaning
// IDLE  | waiting for a header request, req_ready high
// CSUM  | adding the ten IPv4 header words into the accumulator
// FOLD  | folding carries, registering the checksum, loading beat 0
// EMIT  | streaming six header beats under valid/ready
module udp_oe_tx_hdr_gen #(
    parameter int          MAX_PAYLOAD = 1472,
    parameter logic [7:0]  IP_TTL      = 8'h40,
    parameter logic [15:0] ID_INIT     = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        soft_rst,
    input  logic [47:0] cfg_fpga_mac,
    input  logic [31:0] cfg_fpga_ip,
    input  logic [15:0] cfg_fpga_port,
    input  logic [47:0] cfg_host_mac,
    input  logic [31:0] cfg_host_ip,
    input  logic [15:0] cfg_host_port,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_len,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [63:0] hdr_data,
    output logic [7:0]  hdr_keep,
    output logic        hdr_last,
    output logic        hdr_err,
    output logic [15:0] last_checksum_ip
);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    typedef enum logic [1:0] {IDLE, CSUM, FOLD, EMIT} state_t;

    state_t      state;
    logic [47:0] host_mac_q, fpga_mac_q;
    logic [31:0] host_ip_q, fpga_ip_q;
    logic [15:0] host_port_q, fpga_port_q, len_q, id_q;
    logic [19:0] acc;
    logic [3:0]  cnt;
    logic [2:0]  beat;

    logic [15:0]  total_len, udp_len, word, csum_new;
    logic [16:0]  fold1, fold2;
    logic [383:0] hdr_be;

    assign req_ready = reset_n && (state == IDLE) && !soft_rst;
    assign total_len = len_q + 16'd28;
    assign udp_len   = len_q + 16'd8;

    always_comb begin
        word = 16'h0000;
        case (cnt)
            4'd0: word = 16'h4500;
            4'd1: word = total_len;
            4'd2: word = id_q;
            4'd3: word = 16'h4000;
            4'd4: word = {IP_TTL, 8'h11};
            4'd5: word = 16'h0000;
            4'd6: word = fpga_ip_q[31:16];
            4'd7: word = fpga_ip_q[15:0];
            4'd8: word = host_ip_q[31:16];
            4'd9: word = host_ip_q[15:0];
            default: word = 16'h0000;
        endcase
    end

    // Ten 16-bit words cannot exceed 20 bits, so two folds always settle the carry.
    assign fold1    = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
    assign fold2    = {1'b0, fold1[15:0]} + {16'd0, fold1[16]};
    assign csum_new = ~fold2[15:0];

    // Wire-order header, byte 0 in the top bits; padded with zeros to six full beats.
    assign hdr_be = {host_mac_q, fpga_mac_q, 16'h0800, 16'h4500, total_len, id_q,
                     16'h4000, IP_TTL, 8'h11, last_checksum_ip, fpga_ip_q, host_ip_q,
                     fpga_port_q, host_port_q, udp_len, 16'h0000, 48'd0};

    function automatic logic [63:0] beat_of(input logic [383:0] v, input logic [2:0] b);
        logic [63:0] d;
        d = '0;
        for (int k = 0; k < 8; k++)
            d[8*k +: 8] = v[383 - 8*(8*int'(b) + k) -: 8];
        return d;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE; hdr_valid <= 1'b0; hdr_last <= 1'b0; hdr_keep <= '0;
            hdr_data <= '0; hdr_err <= 1'b0; last_checksum_ip <= '0; id_q <= ID_INIT;
            acc <= '0; cnt <= '0; beat <= '0; len_q <= '0;
            host_mac_q <= '0; fpga_mac_q <= '0; host_ip_q <= '0; fpga_ip_q <= '0;
            host_port_q <= '0; fpga_port_q <= '0;
        end else if (soft_rst) begin
            state <= IDLE; hdr_valid <= 1'b0; hdr_last <= 1'b0; hdr_keep <= '0;
            hdr_data <= '0; hdr_err <= 1'b0; last_checksum_ip <= '0; id_q <= ID_INIT;
            acc <= '0; cnt <= '0; beat <= '0;
        end else begin
            hdr_err <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    host_mac_q <= cfg_host_mac; fpga_mac_q <= cfg_fpga_mac;
                    host_ip_q <= cfg_host_ip; fpga_ip_q <= cfg_fpga_ip;
                    host_port_q <= cfg_host_port; fpga_port_q <= cfg_fpga_port;
                    len_q <= req_len; acc <= '0; cnt <= '0;
                    if (req_len > MAX_LEN) hdr_err <= 1'b1;
                    else state <= CSUM;
                end
                CSUM: begin
                    acc <= acc + {4'd0, word};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd9) state <= FOLD;
                end
                FOLD: begin
                    last_checksum_ip <= csum_new;
                    hdr_data <= beat_of(hdr_be, 3'd0);
                    hdr_keep <= 8'hFF; hdr_last <= 1'b0; hdr_valid <= 1'b1;
                    beat <= 3'd0; state <= EMIT;
                end
                EMIT: if (hdr_ready) begin
                    if (beat == 3'd5) begin
                        hdr_valid <= 1'b0; hdr_last <= 1'b0; hdr_keep <= '0; hdr_data <= '0;
                        id_q <= id_q + 16'd1; state <= IDLE;
                    end else begin
                        beat <= beat + 3'd1;
                        hdr_data <= beat_of(hdr_be, beat + 3'd1);
                        hdr_keep <= (beat == 3'd4) ? 8'h03 : 8'hFF;
                        hdr_last <= (beat == 3'd4);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_oe_tx_hdr_gen.sv
// Bench for udp_oe_tx_hdr_gen: random addressing/lengths checked against a byte-level
// header model, with latency, ID wrap, backpressure, rejection and reset scenarios.
module tb_udp_oe_tx_hdr_gen;
    logic        clk = 1'b0;
    logic        reset_n, soft_rst, req_valid, hdr_ready;
    logic [47:0] cfg_fpga_mac, cfg_host_mac;
    logic [31:0] cfg_fpga_ip, cfg_host_ip;
    logic [15:0] cfg_fpga_port, cfg_host_port, req_len;
    logic        req_ready, hdr_valid, hdr_last, hdr_err;
    logic [63:0] hdr_data;
    logic [7:0]  hdr_keep;
    logic [15:0] last_checksum_ip;

    udp_oe_tx_hdr_gen dut (
        .clk(clk), .reset_n(reset_n), .soft_rst(soft_rst),
        .cfg_fpga_mac(cfg_fpga_mac), .cfg_fpga_ip(cfg_fpga_ip), .cfg_fpga_port(cfg_fpga_port),
        .cfg_host_mac(cfg_host_mac), .cfg_host_ip(cfg_host_ip), .cfg_host_port(cfg_host_port),
        .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_data(hdr_data), .hdr_keep(hdr_keep),
        .hdr_last(hdr_last), .hdr_err(hdr_err), .last_checksum_ip(last_checksum_ip)
    );

    always #5 clk = ~clk;

    int          n_checks = 0, n_fail = 0;
    logic [15:0] model_id;
    logic [7:0]  exp_bytes[$];
    logic [63:0] exp_data[6];
    logic [7:0]  exp_keep[6];
    logic        exp_last[6];
    logic [15:0] exp_csum;
    logic [63:0] got_data[$];
    logic [7:0]  got_keep[$];
    logic        got_last[$];
    int          got_lat, got_unstable;
    logic        got_after_valid, got_after_ready, sent_err;

    function automatic void push_be(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_bytes.push_back(v[8*i +: 8]);
    endfunction

    // Reference header from the current cfg_* inputs, built byte by byte in wire order.
    function automatic void build_expected(input logic [15:0] len, input logic [15:0] id);
        int unsigned s;
        logic [15:0] tl, ul;
        tl = len + 16'd28;
        ul = len + 16'd8;
        s = 32'h4500 + {16'd0, tl} + {16'd0, id} + 32'h4000 + 32'h4011 + 32'h0
            + {16'd0, cfg_fpga_ip[31:16]} + {16'd0, cfg_fpga_ip[15:0]}
            + {16'd0, cfg_host_ip[31:16]} + {16'd0, cfg_host_ip[15:0]};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        exp_csum = ~s[15:0];
        exp_bytes.delete();
        push_be({16'd0, cfg_host_mac}, 6); push_be({16'd0, cfg_fpga_mac}, 6);
        push_be(64'h0800, 2); push_be(64'h4500, 2); push_be({48'd0, tl}, 2);
        push_be({48'd0, id}, 2); push_be(64'h4000, 2); push_be(64'h4011, 2);
        push_be({48'd0, exp_csum}, 2); push_be({32'd0, cfg_fpga_ip}, 4);
        push_be({32'd0, cfg_host_ip}, 4); push_be({48'd0, cfg_fpga_port}, 2);
        push_be({48'd0, cfg_host_port}, 2); push_be({48'd0, ul}, 2); push_be(64'h0, 2);
        while (exp_bytes.size() < 48) exp_bytes.push_back(8'h00);
        for (int b = 0; b < 6; b++) begin
            exp_data[b] = '0;
            for (int k = 0; k < 8; k++) exp_data[b][8*k +: 8] = exp_bytes[8*b + k];
            exp_keep[b] = (b == 5) ? 8'h03 : 8'hFF;
            exp_last[b] = (b == 5);
        end
    endfunction

    task automatic randomize_cfg();
        cfg_fpga_mac  = {16'($urandom), $urandom};
        cfg_host_mac  = {16'($urandom), $urandom};
        cfg_fpga_ip   = $urandom;
        cfg_host_ip   = $urandom;
        cfg_fpga_port = 16'($urandom);
        cfg_host_port = 16'($urandom);
    endtask

    // Presents a request, builds the expected header, returns at the negedge after acceptance.
    task automatic send_req(input logic [15:0] len);
        bit ok;
        ok = 0;
        @(negedge clk);
        req_len = len;
        req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (req_ready === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            n_fail++;
            $display("FAIL send_req: req_ready stayed %b, want 1", req_ready);
            $fatal(1, "request never accepted");
        end
        build_expected(len, model_id);
        @(negedge clk);
        req_valid = 1'b0;
        sent_err = hdr_err;
    endtask

    // mode 0: always ready, 1: random ready, 2: random plus a 20-cycle stall on beat 3.
    task automatic collect(input int mode);
        bit          done, stalled, did_stall;
        int          stall_left;
        logic [63:0] hd;
        logic [7:0]  hk;
        logic        hl;
        got_data.delete(); got_keep.delete(); got_last.delete();
        got_lat = -1; got_unstable = 0;
        done = 0; stalled = 0; did_stall = 0; stall_left = 0;
        hd = '0; hk = '0; hl = 1'b0;
        for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (stalled && (hdr_valid !== 1'b1 || hdr_data !== hd || hdr_keep !== hk || hdr_last !== hl))
                got_unstable++;
            if (mode == 2 && !did_stall && hdr_valid && got_data.size() == 3) begin
                stall_left = 20; did_stall = 1;
            end
            if (mode == 0) hdr_ready = 1'b1;
            else if (stall_left > 0) begin hdr_ready = 1'b0; stall_left--; end
            else hdr_ready = 1'($urandom_range(0, 1));
            if (hdr_valid === 1'b1 && got_lat < 0) got_lat = cyc - 1;
            if (hdr_valid === 1'b1 && hdr_ready) begin
                got_data.push_back(hdr_data); got_keep.push_back(hdr_keep); got_last.push_back(hdr_last);
                if (hdr_last === 1'b1 || got_data.size() >= 8) done = 1;
            end
            stalled = (hdr_valid === 1'b1) && !hdr_ready;
            hd = hdr_data; hk = hdr_keep; hl = hdr_last;
        end
        @(negedge clk);
        got_after_valid = hdr_valid;
        got_after_ready = req_ready;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (hdr_valid !== 1'b0 || hdr_last !== 1'b0 || hdr_err !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid=%b last=%b err=%b ready=%b, want all 0",
                     hdr_valid, hdr_last, hdr_err, req_ready);
        end
        n_checks++;
        if (hdr_data !== 64'd0 || hdr_keep !== 8'd0 || last_checksum_ip !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: data=%h keep=%h csum=%h, want 0", hdr_data, hdr_keep, last_checksum_ip);
        end
        reset_n = 1'b1;
        model_id = 16'h0000;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: req_ready=%b, want 1", req_ready);
        end
    endtask

    task automatic test_checksum();
        for (int p = 0; p < 4; p++) begin
            randomize_cfg();
            if (p == 0) begin cfg_fpga_ip = 32'hC0A80002; cfg_host_ip = 32'hC0A80001; end
            send_req(p == 0 ? 16'd1024 : 16'($urandom_range(0, 1472)));
            collect(0);
            n_checks++;
            if (got_data.size() != 6) begin
                n_fail++; $display("FAIL csum_beats p%0d: got %0d beats, want 6", p, got_data.size());
            end
            for (int b = 0; b < 6 && b < got_data.size(); b++) begin
                n_checks++;
                if (got_data[b] !== exp_data[b] || got_keep[b] !== exp_keep[b] || got_last[b] !== exp_last[b]) begin
                    n_fail++;
                    $display("FAIL csum_beat p%0d b%0d: got %h/%h/%b, want %h/%h/%b", p, b,
                             got_data[b], got_keep[b], got_last[b], exp_data[b], exp_keep[b], exp_last[b]);
                end
            end
            n_checks++;
            if (last_checksum_ip !== exp_csum) begin
                n_fail++; $display("FAIL csum_reg p%0d: got %h, want %h", p, last_checksum_ip, exp_csum);
            end
            if (p == 0 && got_data.size() == 6) begin
                n_checks++;
                if (last_checksum_ip !== 16'hB57D) begin
                    n_fail++; $display("FAIL csum_vector: got %h, want B57D", last_checksum_ip);
                end
                n_checks++;
                if ({got_data[2][7:0], got_data[2][15:8]} !== 16'h041C ||
                    {got_data[4][55:48], got_data[4][63:56]} !== 16'h0408) begin
                    n_fail++;
                    $display("FAIL len_vector: total=%h udp=%h, want 041C 0408",
                             {got_data[2][7:0], got_data[2][15:8]}, {got_data[4][55:48], got_data[4][63:56]});
                end
            end
            model_id = model_id + 16'd1;
        end
    endtask

    task automatic test_latency_id();
        logic [15:0] want_id;
        @(negedge clk); soft_rst = 1'b1;
        @(negedge clk); soft_rst = 1'b0;
        model_id = 16'h0000;
        for (int p = 0; p < 4; p++) begin
            if (p == 2) begin
                force dut.id_q = 16'hFFFF;
                @(negedge clk);
                release dut.id_q;
                model_id = 16'hFFFF;
            end
            want_id = model_id;
            randomize_cfg();
            send_req(16'($urandom_range(0, 1472)));
            collect(0);
            n_checks++;
            if (got_lat != 11) begin
                n_fail++; $display("FAIL latency p%0d: got %0d cycles, want 11", p, got_lat);
            end
            n_checks++;
            if (got_data.size() != 6 || got_data[2][31:16] !== {want_id[7:0], want_id[15:8]}
                || got_data[5] !== exp_data[5]) begin
                n_fail++; $display("FAIL id p%0d: beats=%0d id_bytes=%h, want 6 beats id %h",
                                   p, got_data.size(), got_data.size() > 2 ? got_data[2][31:16] : 16'h0, want_id);
            end
            n_checks++;
            if (got_after_valid !== 1'b0 || got_after_ready !== 1'b1) begin
                n_fail++; $display("FAIL after_last p%0d: valid=%b ready=%b, want 0 1",
                                   p, got_after_valid, got_after_ready);
            end
            model_id = model_id + 16'd1;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] len;
        len = 16'($urandom_range(0, 1472));
        randomize_cfg();
        for (int m = 0; m < 3; m++) begin
            send_req(len);
            collect(m);
            n_checks++;
            if (got_data.size() != 6 || got_unstable != 0) begin
                n_fail++; $display("FAIL bp_count m%0d: beats=%0d unstable=%0d, want 6 0", m, got_data.size(), got_unstable);
            end
            for (int b = 0; b < 6 && b < got_data.size(); b++) begin
                n_checks++;
                if (got_data[b] !== exp_data[b] || got_keep[b] !== exp_keep[b] || got_last[b] !== exp_last[b]) begin
                    n_fail++;
                    $display("FAIL bp_beat m%0d b%0d: got %h/%h/%b, want %h/%h/%b", m, b,
                             got_data[b], got_keep[b], got_last[b], exp_data[b], exp_keep[b], exp_last[b]);
                end
            end
            model_id = model_id + 16'd1;
        end
    endtask

    task automatic test_reject();
        int seen_valid;
        randomize_cfg();
        send_req(16'd1473);
        n_checks++;
        if (sent_err !== 1'b1) begin
            n_fail++; $display("FAIL reject_err: hdr_err=%b, want 1", sent_err);
        end
        seen_valid = 0;
        @(negedge clk);
        n_checks++;
        if (hdr_err !== 1'b0) begin
            n_fail++; $display("FAIL reject_pulse: hdr_err=%b second cycle, want 0", hdr_err);
        end
        for (int i = 0; i < 20; i++) begin
            if (hdr_valid !== 1'b0) seen_valid++;
            @(negedge clk);
        end
        n_checks++;
        if (seen_valid != 0) begin
            n_fail++; $display("FAIL reject_valid: hdr_valid high %0d cycles, want 0", seen_valid);
        end
        for (int p = 0; p < 2; p++) begin
            send_req(p == 0 ? 16'd1472 : 16'd0);
            n_checks++;
            if (sent_err !== 1'b0) begin
                n_fail++; $display("FAIL accept_err p%0d: hdr_err=%b, want 0", p, sent_err);
            end
            collect(1);
            n_checks++;
            if (got_data.size() != 6 || got_data[2] !== exp_data[2] || got_data[4] !== exp_data[4]) begin
                n_fail++; $display("FAIL edge_len p%0d: beats=%0d b2=%h b4=%h, want %h %h", p, got_data.size(),
                                   got_data.size() > 4 ? got_data[2] : 64'h0, got_data.size() > 4 ? got_data[4] : 64'h0,
                                   exp_data[2], exp_data[4]);
            end else if (p == 0) begin
                n_checks++;
                if ({got_data[2][7:0], got_data[2][15:8]} !== 16'h05DC) begin
                    n_fail++; $display("FAIL max_len: total_len=%h, want 05DC", {got_data[2][7:0], got_data[2][15:8]});
                end
            end else begin
                n_checks++;
                if ({got_data[4][55:48], got_data[4][63:56]} !== 16'h0008) begin
                    n_fail++; $display("FAIL zero_len: udp_len=%h, want 0008", {got_data[4][55:48], got_data[4][63:56]});
                end
            end
            model_id = model_id + 16'd1;
        end
    endtask

    task automatic test_cfg_isolation();
        randomize_cfg();
        send_req(16'($urandom_range(0, 1472)));
        fork
            collect(1);
            begin
                repeat (3) @(negedge clk);
                cfg_host_mac = {16'($urandom), $urandom}; cfg_fpga_ip = $urandom;
                repeat (12) @(negedge clk);
                cfg_host_mac = {16'($urandom), $urandom}; cfg_fpga_ip = $urandom; cfg_host_port = 16'($urandom);
            end
        join
        n_checks++;
        if (got_data.size() != 6) begin
            n_fail++; $display("FAIL iso_beats: got %0d beats, want 6", got_data.size());
        end
        for (int b = 0; b < 6 && b < got_data.size(); b++) begin
            n_checks++;
            if (got_data[b] !== exp_data[b]) begin
                n_fail++; $display("FAIL iso_beat b%0d: got %h, want %h", b, got_data[b], exp_data[b]);
            end
        end
        model_id = model_id + 16'd1;
    endtask

    task automatic test_async_reset();
        randomize_cfg();
        send_req(16'($urandom_range(0, 1472)));
        repeat (4) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if (last_checksum_ip !== 16'd0 || req_ready !== 1'b0 || hdr_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_rst: csum=%h ready=%b valid=%b, want 0 0 0",
                               last_checksum_ip, req_ready, hdr_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_id = 16'h0000;
        randomize_cfg();
        send_req(16'($urandom_range(0, 1472)));
        collect(1);
        n_checks++;
        if (got_data.size() != 6) begin
            n_fail++; $display("FAIL async_beats: got %0d beats, want 6", got_data.size());
        end
        for (int b = 0; b < 6 && b < got_data.size(); b++) begin
            n_checks++;
            if (got_data[b] !== exp_data[b] || got_keep[b] !== exp_keep[b] || got_last[b] !== exp_last[b]) begin
                n_fail++; $display("FAIL async_beat b%0d: got %h/%h/%b, want %h/%h/%b", b,
                                   got_data[b], got_keep[b], got_last[b], exp_data[b], exp_keep[b], exp_last[b]);
            end
        end
        model_id = model_id + 16'd1;
    endtask

    task automatic test_soft_reset();
        int waited;
        randomize_cfg();
        send_req(16'($urandom_range(0, 1472)));
        hdr_ready = 1'b1;
        waited = 0;
        while (hdr_valid !== 1'b1 && waited < 30) begin @(negedge clk); waited++; end
        repeat (2) @(negedge clk);
        n_checks++;
        if (hdr_data !== exp_data[2] || hdr_last !== 1'b0) begin
            n_fail++; $display("FAIL soft_beat2: got %h last=%b, want %h last=0", hdr_data, hdr_last, exp_data[2]);
        end
        soft_rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (hdr_valid !== 1'b0 || hdr_last !== 1'b0 || req_ready !== 1'b0 || hdr_keep !== 8'd0) begin
            n_fail++; $display("FAIL soft_rst: valid=%b last=%b ready=%b keep=%h, want 0 0 0 00",
                               hdr_valid, hdr_last, req_ready, hdr_keep);
        end
        soft_rst = 1'b0;
        model_id = 16'h0000;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || last_checksum_ip !== 16'd0) begin
            n_fail++; $display("FAIL soft_idle: ready=%b csum=%h, want 1 0000", req_ready, last_checksum_ip);
        end
        send_req(16'($urandom_range(0, 1472)));
        collect(0);
        n_checks++;
        if (got_data.size() != 6 || got_data[2] !== exp_data[2] || got_data[3] !== exp_data[3]) begin
            n_fail++; $display("FAIL soft_fresh: beats=%0d b2=%h, want 6 %h", got_data.size(),
                               got_data.size() > 2 ? got_data[2] : 64'h0, exp_data[2]);
        end
        model_id = model_id + 16'd1;
    endtask

    initial begin
        reset_n = 1'b0; soft_rst = 1'b0; req_valid = 1'b0; req_len = '0; hdr_ready = 1'b0;
        model_id = 16'h0000;
        randomize_cfg();
        test_reset();
        test_checksum();
        test_latency_id();
        test_backpressure();
        test_reject();
        test_cfg_isolation();
        test_async_reset();
        test_soft_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/udp_oe_tx_hdr_gen.md
Name: udp_oe_tx_hdr_gen

Overview:
- TX header generator downstream of the UDP offload engine CSR block.
- Consumes the CSR-programmed addressing fields (FPGA/host MAC, IP, UDP port) and a per-packet payload-length request.
- Computes the IPv4 header checksum sequentially, then emits the 42-byte Ethernet/IPv4/UDP header as a 64-bit valid/ready stream to the TX packetizer.
- Reports the last computed checksum back for CSR readback.

Parameters:
- MAX_PAYLOAD, 1472: largest legal UDP payload in bytes; longer requests are rejected.
- IP_TTL, 8'h40: TTL byte inserted in every IPv4 header.
- ID_INIT, 16'h0000: IPv4 identification value after reset or soft reset.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- soft_rst  in  1  synchronous soft reset (CSR tx_rst), active high
- cfg_fpga_mac  in  48  source MAC
- cfg_fpga_ip  in  32  source IP
- cfg_fpga_port  in  16  source UDP port
- cfg_host_mac  in  48  destination MAC
- cfg_host_ip  in  32  destination IP
- cfg_host_port  in  16  destination UDP port
- req_valid  in  1  header request
- req_ready  out  1  request accepted when valid&ready
- req_len  in  16  UDP payload bytes
- hdr_valid  out  1  header beat valid
- hdr_ready  in  1  downstream accepts beat
- hdr_data  out  64  header beat; byte n in bits [8n+7:8n], wire order byte 0 first
- hdr_keep  out  8  byte enables
- hdr_last  out  1  final header beat
- hdr_err  out  1  one-cycle pulse: request rejected
- last_checksum_ip  out  16  checksum of most recent header

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset (reset_n low) and soft_rst both force the following; soft_rst aborts any state immediately, including mid-EMIT with no hdr_last:
  - state IDLE
  - hdr_valid=0, hdr_last=0, hdr_keep=0, hdr_data=0, hdr_err=0, req_ready=0 during reset
  - last_checksum_ip=0, ID counter=ID_INIT
- req_ready = (state==IDLE) & ~soft_rst. It is registered-state based; there is no combinational path from hdr_ready.
- On acceptance (edge E0), all cfg_* fields and req_len are latched. Later CSR changes do not affect the header in flight.
- Rejection: if latched req_len > MAX_PAYLOAD:
  - hdr_err pulses for the cycle after E0
  - state stays IDLE and the ID counter is unchanged
  - no beats are emitted
- States: IDLE -> CSUM -> FOLD -> EMIT -> IDLE.
- CSUM: edges E1..E10 each add one 16-bit word into a 20-bit accumulator (cleared at E0).
  - Word order: 16'h4500, total_len, id, 16'h4000, {IP_TTL,8'h11}, 16'h0000, src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0].
- FOLD (edge E11):
  - sum16 = acc[15:0] + acc[19:16]
  - fold the carry again
  - checksum = ~result
  - checksum is registered into last_checksum_ip and beat 0 is loaded
  - hdr_valid rises after E11, i.e. 11 cycles after the accepting edge when hdr_ready is held high
- Length fields:
  - total_len = req_len + 28
  - udp_len = req_len + 8
  - both are 16-bit; no overflow is possible under MAX_PAYLOAD.
- Header bytes 0..41:
  - host_mac (MSB first)
  - fpga_mac
  - 08 00
  - 45 00
  - total_len
  - id
  - 40 00
  - IP_TTL
  - 11
  - checksum
  - fpga_ip
  - host_ip
  - fpga_port
  - host_port
  - udp_len
  - 00 00 (UDP checksum disabled)
- EMIT: 6 beats. Beats 0-4 have keep=8'hFF; beat 5 has keep=8'h03, last=1, and bytes 2-7 zero.
- Beats advance only on hdr_valid&hdr_ready. While hdr_ready is low, data, keep and last hold stable and hdr_valid stays high.
- After the beat-5 handshake: state returns to IDLE and the ID counter increments, wrapping 16'hFFFF->16'h0000.
- req_ready is high in the cycle after the beat-5 handshake. There is no back-to-back overlap.
- req_valid held high while busy is ignored until IDLE.

Test Plan:
- Checksum and length fields: fpga_ip=C0A80002, host_ip=C0A80001, req_len=1024, id=0 -> total_len=041C, udp_len=0408, last_checksum_ip=B57D, 6 beats, beat 5 keep=03 with last.
- Latency and ID wrap: hdr_ready held 1 -> hdr_valid first high 11 cycles after accept. Back-to-back requests get ids 0000, 0001. Force ID to FFFF -> next header uses FFFF, the following one uses 0000.
- Backpressure: hdr_ready toggled randomly (including 0 for 20 cycles on beat 3) -> beat sequence identical to the no-stall case; no beat dropped or duplicated.
- Rejection: req_len=1473 -> hdr_err single pulse, no hdr_valid, ID unchanged. req_len=1472 -> accepted, total_len=05DC. req_len=0 -> accepted, udp_len=0008.
- Config isolation: change cfg_host_mac during CSUM and EMIT -> the emitted header carries the value latched at acceptance.
- Resets: soft_rst asserted during beat 2 -> next cycle hdr_valid=0, IDLE, ID=ID_INIT, no hdr_last. reset_n dropped asynchronously mid-CSUM -> outputs clear without a clock edge; a fresh request afterwards produces a correct header.
